// File: rtl/hack_fetch.sv
// ---------------------------------------------------------------------------
// hack_fetch
//
// Instruction fetch stage sitting between the program counter and the Hack
// ROM32K. It owns the PC, drives the ROM address, absorbs the ROM's one-cycle
// registered read latency and presents instruction + PC to decode through a
// valid/ready handshake. Execute can redirect the stream at any time; all
// stale fetches are flushed. Sustains one instruction per cycle.
//
// Ports
//   clock        rising-edge clock
//   reset        synchronous, active-high reset
//   rom_addr     word address sent to the ROM (data returns next cycle)
//   rom_data     ROM registered output for the previous cycle's rom_addr
//   jump_valid   redirect request from execute
//   jump_addr    redirect target
//   instr_valid  instr / instr_pc hold a valid instruction
//   instr        instruction word for decode
//   instr_pc     address the instruction was fetched from
//   instr_ready  decode accepts the instruction this cycle
// ---------------------------------------------------------------------------
module hack_fetch #(
    parameter int                ADDR_W   = 15,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              jump_valid,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready
);

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    // Program counter and the fetch that is currently inside the ROM pipeline.
    logic [ADDR_W-1:0] pc;
    logic              inflight;
    logic [ADDR_W-1:0] inflight_pc;

    // Two-entry output buffer; slot 0 is always the head shown to decode.
    logic [DATA_W-1:0] data0;
    logic [DATA_W-1:0] data1;
    logic [ADDR_W-1:0] pc0;
    logic [ADDR_W-1:0] pc1;
    logic [1:0]        count;

    logic       pop;
    logic       issue;
    logic [1:0] occ;
    logic [1:0] occ_after;

    // Outputs come straight from buffer registers, so there is no
    // combinational path from rom_data to decode.
    assign instr_valid = (count != 2'd0);
    assign instr       = data0;
    assign instr_pc    = pc0;

    assign pop = instr_valid & instr_ready;

    // Occupancy counts the fetch still in the ROM, so a new fetch is issued
    // only if it is guaranteed a buffer slot when it returns.
    assign occ       = count + {1'b0, inflight};
    assign occ_after = occ - {1'b0, pop};
    assign issue     = jump_valid | (occ_after < 2'd2);

    // A redirect reaches the ROM in the same cycle so the target costs no
    // extra latency; during reset the ROM is pointed at the restart address.
    always_comb begin
        rom_addr = pc;
        if (reset) begin
            rom_addr = RESET_PC;
        end else if (jump_valid) begin
            rom_addr = jump_addr;
        end
    end

    // All fetch-stage state. A jump discards everything still buffered or in
    // flight (a head accepted in the same cycle has already been consumed)
    // and restarts the pipeline at the target. Otherwise the returning fetch
    // is appended behind whatever survives this cycle's pop.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            count       <= 2'd0;
            data0       <= '0;
            data1       <= '0;
            pc0         <= '0;
            pc1         <= '0;
        end else if (jump_valid) begin
            count       <= 2'd0;
            inflight    <= 1'b1;
            inflight_pc <= jump_addr;
            pc          <= jump_addr + PC_ONE;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= pc;
                pc          <= pc + PC_ONE;
            end

            case ({pop, inflight})
                2'b10: begin
                    data0 <= data1;
                    pc0   <= pc1;
                    count <= count - 2'd1;
                end
                2'b01: begin
                    if (count == 2'd0) begin
                        data0 <= rom_data;
                        pc0   <= inflight_pc;
                    end else begin
                        data1 <= rom_data;
                        pc1   <= inflight_pc;
                    end
                    count <= count + 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        data0 <= rom_data;
                        pc0   <= inflight_pc;
                    end else begin
                        data0 <= data1;
                        pc0   <= pc1;
                        data1 <= rom_data;
                        pc1   <= inflight_pc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hack_fetch.sv
// ---------------------------------------------------------------------------
// tb_hack_fetch
//
// Drives hack_fetch with directed and random stimulus, models the ROM as a
// registered lookup word(a) = a ^ 16'hA5A5, and compares every cycle against
// a timestamped queue model: each issued fetch becomes visible two cycles
// after issue, a jump empties the queue, reset empties it and rewinds the PC.
// ---------------------------------------------------------------------------
module tb_hack_fetch;

    localparam int          ADDR_W   = 15;
    localparam int          DATA_W   = 16;
    localparam logic [14:0] RESET_PC = 15'd0;

    logic              clock = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              jump_valid;
    logic [ADDR_W-1:0] jump_addr;
    logic              instr_valid;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_ready;

    hack_fetch #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .RESET_PC(RESET_PC)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .jump_valid (jump_valid),
        .jump_addr  (jump_addr),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_ready(instr_ready)
    );

    always #5 clock = ~clock;

    // Registered ROM: word for this cycle's address appears next cycle.
    always_ff @(posedge clock) begin
        rom_data <= {1'b0, rom_addr} ^ 16'hA5A5;
    end

    // Reference model: every fetch ever issued and not yet consumed or
    // flushed, with the cycle from which decode may see it.
    typedef struct {
        logic [14:0] pc;
        int          avail;
    } fetch_t;

    fetch_t      pend[$];
    logic [14:0] next_pc;
    int          now;
    bit          after_reset;

    int checks_total  = 0;
    int checks_passed = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks_total++;
        if (observed === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     tag, observed, expected, now);
        end
    endtask

    function automatic bit head_visible();
        if (pend.size() == 0) return 1'b0;
        return pend[0].avail <= now;
    endfunction

    // One clock cycle: drive inputs after the falling edge, compare outputs
    // shortly after, then advance the model across the coming rising edge.
    task automatic applyStimulus(input bit rst, input bit jv,
                                 input logic [14:0] ja, input bit rdy);
        logic [14:0] exp_rom;
        bit          vis;
        bit          pop;
        int          occ;

        @(negedge clock);
        reset       = rst;
        jump_valid  = jv;
        jump_addr   = ja;
        instr_ready = rdy;
        #1;

        exp_rom = rst ? RESET_PC : (jv ? ja : next_pc);
        checkOutput("rom_addr", 32'(rom_addr), 32'(exp_rom));

        vis = head_visible();
        checkOutput("instr_valid", 32'(instr_valid), 32'(vis));
        if (vis) begin
            checkOutput("instr_pc", 32'(instr_pc), 32'(pend[0].pc));
            checkOutput("instr", 32'(instr), 32'({1'b0, pend[0].pc} ^ 16'hA5A5));
        end
        if (after_reset) begin
            checkOutput("reset_instr", 32'(instr), 32'd0);
            checkOutput("reset_instr_pc", 32'(instr_pc), 32'd0);
        end

        after_reset = rst;
        if (rst) begin
            pend.delete();
            next_pc = RESET_PC;
        end else begin
            pop = vis && rdy;
            occ = pend.size();
            if (pop) void'(pend.pop_front());
            if (jv) begin
                pend.delete();
                pend.push_back('{ja, now + 2});
                next_pc = ja + 15'd1;
            end else if (occ - int'(pop) < 2) begin
                pend.push_back('{next_pc, now + 2});
                next_pc = next_pc + 15'd1;
            end
        end
        now++;
    endtask

    // Runs with decode ready until the model's next head is the target PC.
    task automatic runUntilHead(input logic [14:0] target);
        bit found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (head_visible() && pend[0].pc == target) begin
                found = 1'b1;
                break;
            end
            applyStimulus(1'b0, 1'b0, 15'd0, 1'b1);
        end
        checkOutput("wait_head", 32'(found), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset       = 1'b1;
        jump_valid  = 1'b0;
        jump_addr   = '0;
        instr_ready = 1'b0;
        now         = 0;
        next_pc     = RESET_PC;
        after_reset = 1'b1;
        repeat (2) @(posedge clock);

        // Reset release with decode always ready: sequential stream.
        $display("[TB] reset release, streaming");
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0, 15'd0, 1'b1);

        // Backpressure while pc 4 is at the head.
        $display("[TB] backpressure at pc 4");
        applyStimulus(1'b1, 1'b0, 15'd0, 1'b1);
        runUntilHead(15'd4);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 15'd0, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 15'd0, 1'b1);

        // Jump with a full buffer and decode stalled.
        $display("[TB] jump with full buffer");
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 15'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 15'h0020, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 15'd0, 1'b1);

        // Jump coinciding with acceptance of pc 9.
        $display("[TB] jump on handshake");
        applyStimulus(1'b0, 1'b1, 15'd6, 1'b1);
        runUntilHead(15'd9);
        applyStimulus(1'b0, 1'b1, 15'h0100, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 15'd0, 1'b1);

        // Back-to-back jumps, last one wins.
        applyStimulus(1'b0, 1'b1, 15'h0200, 1'b1);
        applyStimulus(1'b0, 1'b1, 15'h0300, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 15'd0, 1'b1);

        // PC wrap at the top of the address space.
        $display("[TB] pc wrap");
        applyStimulus(1'b0, 1'b1, 15'h7FFE, 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 15'd0, 1'b1);

        // Reset with full buffer and a coincident jump, then random traffic.
        $display("[TB] reset over jump, random traffic");
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 15'd0, 1'b0);
        applyStimulus(1'b1, 1'b1, 15'h0055, 1'b0);
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 99) == 0,
                          $urandom_range(0, 15) == 0,
                          15'($urandom),
                          $urandom_range(0, 2) != 0);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
